sll_iter: RTL

SLL_ITER -- requirements
Module: sll_iter

---
 rtl/sll_iter.sv | 104 ++++++++++
 1 files changed

// File: rtl/sll_iter.sv
// rtl/sll_iter.sv - iterative 32-bit logical left shifter, one barrel stage per cycle
module sll_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_start,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_work;
    logic [4:0]  r_shamt;
    logic [2:0]  r_cnt;
    logic [31:0] r_data_out;
    logic        r_data_ready;
    logic        r_busy;

    logic [31:0] w_stage;
    logic        w_bit;

    // Stage k shifts by 2^k only when the captured shamt bit k is set.
    always_comb begin
        w_bit   = 1'b0;
        w_stage = r_work;
        case (r_cnt)
            3'd4: begin w_bit = r_shamt[4]; w_stage = {r_work[15:0], 16'h0}; end
            3'd3: begin w_bit = r_shamt[3]; w_stage = {r_work[23:0], 8'h0};  end
            3'd2: begin w_bit = r_shamt[2]; w_stage = {r_work[27:0], 4'h0};  end
            3'd1: begin w_bit = r_shamt[1]; w_stage = {r_work[29:0], 2'h0};  end
            3'd0: begin w_bit = r_shamt[0]; w_stage = {r_work[30:0], 1'b0};  end
            default: begin w_bit = 1'b0; w_stage = r_work; end
        endcase
        if (!w_bit) begin
            w_stage = r_work;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_work       <= 32'h0;
            r_shamt      <= 5'h0;
            r_cnt        <= 3'd0;
            r_data_out   <= 32'h0;
            r_data_ready <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_data_ready <= 1'b0;
                    if (ctrl_start) begin
                        r_work  <= data_in;
                        r_shamt <= shamt;
                        r_cnt   <= 3'd4;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= w_stage;
                    if (r_cnt == 3'd0) begin
                        r_data_out   <= w_stage;
                        r_data_ready <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                DONE: begin
                    r_data_ready <= 1'b0;
                    if (ctrl_start) begin
                        r_work  <= data_in;
                        r_shamt <= shamt;
                        r_cnt   <= 3'd4;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_data_ready <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_ready = r_data_ready;
    assign busy       = r_busy;

endmodule
